// File: rtl/uart_ctrl.sv
// Bus-side UART controller: RX/TX byte FIFOs, TX start handshake FSM,
// three-register map (TXD/RXD/CON) and a registered level interrupt.
module uart_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2} state_t;

  localparam logic [1:0]     A_TXD    = 2'd0;
  localparam logic [1:0]     A_RXD    = 2'd1;
  localparam logic [1:0]     A_CON    = 2'd2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic             rx_status_q;
  logic [PTR_W-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [PTR_W:0]   rx_cnt_q, rx_cnt_d;
  logic [PTR_W-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PTR_W:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_en_q, tx_en_d;
  logic             rxie_q, rxie_d, txie_q, txie_d;
  logic             ovr_q, ovr_d, txdone_q, txdone_d, txovf_q, txovf_d;
  logic             irq_q, irq_d;
  logic [7:0]       rx_mem_q [DEPTH];
  logic [7:0]       tx_mem_q [DEPTH];

  logic rx_rise, rx_full, rx_push, rx_pop, ovr_set;
  logic tx_wr, tx_full, tx_push, tx_pop, txovf_set, txdone_set;
  logic con_wr, rxne, txidle;
  logic [7:0] con_val;

  // RX side: edge-detected push, bus-read pop; full FIFO accepts only alongside a pop
  assign rx_rise = rx_status & ~rx_status_q;
  assign rx_full = (rx_cnt_q == FULL_CNT);
  assign rx_pop  = rd & (addr == A_RXD) & (rx_cnt_q != '0);
  assign rx_push = rx_rise & (~rx_full | rx_pop);
  assign ovr_set = rx_rise & rx_full & ~rx_pop;
  assign rxne    = (rx_cnt_q != '0);

  assign tx_wr     = wr & (addr == A_TXD);
  assign tx_full   = (tx_cnt_q == FULL_CNT);
  assign tx_push   = tx_wr & (~tx_full | tx_pop);
  assign txovf_set = tx_wr & tx_full & ~tx_pop;
  assign txidle    = (tx_cnt_q == '0) & (state_q == IDLE);

  assign con_wr  = wr & (addr == A_CON);
  assign con_val = {txovf_q, txidle, txdone_q, ovr_q, tx_full, rxne, txie_q, rxie_q};

  always_comb begin
    rx_wp_d  = rx_wp_q + PTR_W'(rx_push);
    rx_rp_d  = rx_rp_q + PTR_W'(rx_pop);
    rx_cnt_d = rx_cnt_q + (PTR_W+1)'(rx_push) - (PTR_W+1)'(rx_pop);
    tx_wp_d  = tx_wp_q + PTR_W'(tx_push);
    tx_rp_d  = tx_rp_q + PTR_W'(tx_pop);
    tx_cnt_d = tx_cnt_q + (PTR_W+1)'(tx_push) - (PTR_W+1)'(tx_pop);
  end

  // TX FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((tx_cnt_q != '0) && tx_status) state_d = START;
      START:   if (!tx_status) state_d = BUSY;
      BUSY:    if (tx_status) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // TX FSM outputs; tx_data keeps the last popped byte
  always_comb begin
    tx_pop     = (state_q == IDLE) && (tx_cnt_q != '0) && tx_status;
    txdone_set = (state_q == BUSY) && tx_status;
    tx_en_d    = tx_pop;
    tx_data_d  = tx_pop ? tx_mem_q[tx_rp_q] : tx_data_q;
  end

  // CON: a set event in the same cycle as its W1C clear leaves the bit set
  always_comb begin
    rxie_d   = con_wr ? wdata[0] : rxie_q;
    txie_d   = con_wr ? wdata[1] : txie_q;
    ovr_d    = ovr_set    | (ovr_q    & ~(con_wr & wdata[4]));
    txdone_d = txdone_set | (txdone_q & ~(con_wr & wdata[5]));
    txovf_d  = txovf_set  | (txovf_q  & ~(con_wr & wdata[7]));
    irq_d    = (rxie_q & rxne) | (txie_q & txdone_q) | ovr_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_RXD:   rdata[7:0] = rxne ? rx_mem_q[rx_rp_q] : 8'h00;
      A_CON:   rdata[7:0] = con_val;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rx_status_q <= 1'b0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      rx_cnt_q    <= '0;
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      tx_cnt_q    <= '0;
      tx_data_q   <= '0;
      tx_en_q     <= 1'b0;
      rxie_q      <= 1'b0;
      txie_q      <= 1'b0;
      ovr_q       <= 1'b0;
      txdone_q    <= 1'b0;
      txovf_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_status_q <= rx_status;
      rx_wp_q     <= rx_wp_d;
      rx_rp_q     <= rx_rp_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wp_q     <= tx_wp_d;
      tx_rp_q     <= tx_rp_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_en_q     <= tx_en_d;
      rxie_q      <= rxie_d;
      txie_q      <= txie_d;
      ovr_q       <= ovr_d;
      txdone_q    <= txdone_d;
      txovf_q     <= txovf_d;
      irq_q       <= irq_d;
    end
  end

  // FIFO storage is never read while empty, so it needs no reset
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    if (tx_push) tx_mem_q[tx_wp_q] <= wdata;
  end

  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign irq     = irq_q;

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Bus-side controller for the UART peripheral. It sits between the CPU peripheral bus and the UART receiver/transmitter pair. It buffers received bytes in an RX FIFO and queues CPU-written bytes in a TX FIFO, which it feeds to the transmitter through a tx_en/tx_status handshake. It exposes a three-register map and a level interrupt.

Parameters:
DEPTH, 4, entries per FIFO (RX and TX); power of 2, minimum 2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
addr  in  2  word select: 0=TXD, 1=RXD, 2=CON, 3=reserved.
rd  in  1  bus read strobe, one cycle per access.
wr  in  1  bus write strobe, one cycle per access.
wdata  in  8  write data.
rdata  out  32  read data; combinational from addr, upper bits zero.
rx_status  in  1  receiver byte-done indication, in clk domain; a new byte is each 0->1 edge.
rx_data  in  8  receiver byte, valid while rx_status=1.
tx_data  out  8  byte to transmitter.
tx_en  out  1  one-cycle start pulse to transmitter.
tx_status  in  1  transmitter idle flag (1=idle, 0=sending).
irq  out  1  level interrupt.

Behaviour:
- Reset (reset=0, any time, mid-transfer included): both FIFOs empty, all pointers, counts and CON bits 0, FSM=IDLE, tx_en=0, tx_data=0, irq=0.
- RX push: on the cycle after rx_status rises (edge detected via a registered copy), rx_data is written to the RX FIFO. A held-high rx_status pushes once only.
- RX read: rdata[7:0] shows the head entry when addr=1. rd with addr=1 pops one entry. rd on an empty FIFO returns 0 and leaves pointers unchanged.
- RX full: a push with no simultaneous pop drops the byte and sets OVR. A push and pop in the same cycle when full both succeed and do not set OVR.
- TXD write: wr with addr=0 pushes wdata[7:0] into the TX FIFO. A write while the TX FIFO is full is ignored and sets TXOVF.
- TX FSM:
  - IDLE: if the TX FIFO is not empty and tx_status=1, pop the head into tx_data, assert tx_en for one cycle, go to START.
  - START: wait for tx_status=0, then go to BUSY.
  - BUSY: wait for tx_status=1, then set TXDONE and go to IDLE.
  - An entry popped in IDLE may be refilled by a same-cycle wr.
  - tx_data holds its value until the next pop.
- CON register (addr=2):
  - bit0 RXIE (R/W).
  - bit1 TXIE (R/W).
  - bit2 RXNE (RO, RX count != 0).
  - bit3 TXFULL (RO).
  - bit4 OVR (W1C).
  - bit5 TXDONE (W1C).
  - bit6 TXIDLE (RO, TX FIFO empty and FSM=IDLE).
  - bit7 TXOVF (W1C).
  - If a set event and a W1C clear of the same bit occur in one cycle, the set wins.
- irq = (RXIE & RXNE) | (TXIE & TXDONE) | OVR. irq is registered and updates the cycle after its sources change.
- Counts are PTR_W+1 bits wide. Pointers wrap modulo DEPTH.
- Accesses to addr=3 read 0; writes to addr=3 have no effect.

Test Plan:
- Reset release, then read CON -> 0x40 (TXIDLE only); irq=0, tx_en=0.
- Write TXD 0x55 then 0xAA. Model tx_status dropping 3 cycles after tx_en and rising 160 cycles later -> two tx_en pulses with tx_data 0x55 then 0xAA, TXDONE=1. Set TXIE -> irq=1. W1C bit5 -> irq=0.
- Pulse rx_status with bytes 0x31, 0x32, 0x33 -> RXNE=1. Three RXD reads return 0x31, 0x32, 0x33. A fourth read returns 0 and RXNE=0.
- Send 5 RX bytes with no reads -> FIFO holds the first 4, OVR=1, irq=1. Fifth byte with a same-cycle pop on a full FIFO -> accepted, OVR stays 0 (separate run).
- Write 5 TXD bytes while tx_status=0 -> TXFULL=1, TXOVF=1, only 4 bytes transmitted after tx_status goes to 1.
- Assert reset during BUSY with 2 bytes queued -> tx_en stays 0, FIFOs empty, CON=0x40 after release.
